// File: rtl/cbus_arbiter_n.sv
// cbus_arbiter_n -- N-to-1 burst arbiter for the simplified cache bus.
//
// Grants one master per burst and holds the grant until the response beat
// carrying ready && last, then returns to IDLE for one bubble cycle before
// re-arbitrating. Arbitration is round-robin (RR_MODE=1) or fixed priority
// with index 0 highest (RR_MODE=0).
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   ireqs       per-master requests (cbus_req_t, 151 b each)
//   iresps      per-master responses (cbus_resp_t, 66 b each)
//   oreq        request forwarded to the AXI converter
//   oresp       response from the AXI converter
//   busy        a burst is in progress
//   grant_idx   index of the granted master, valid while busy=1

package common;

    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter_n
    import common::*;
#(
    parameter int NREQ    = 2,
    parameter bit RR_MODE = 1'b1,
    parameter int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NREQ],
    output cbus_resp_t       iresps [NREQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] scan_idx;
    logic             any_valid;

    // Scan starting at rr_ptr (round-robin) or at 0 (fixed priority); the
    // first valid index seen wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDX_W'(((RR_MODE ? 32'(rr_ptr) : 32'd0) + k) % NREQ);
            if (!any_valid && ireqs[scan_idx].valid) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    // Datapath is only opened while BUSY, so a request never reaches oreq
    // in the same cycle it is arbitrated.
    always_comb begin
        oreq = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            iresps[k] = '0;
        end
        if (state == BUSY) begin
            oreq = ireqs[grant_idx];
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (grant_idx == IDX_W'(k)) begin
                    iresps[k] = oresp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        grant_idx <= winner;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (RR_MODE) begin
                            rr_ptr <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Testbench for cbus_arbiter_n: a 4-port round-robin instance, a 4-port
// fixed-priority instance sharing the same inputs, and a single-port
// instance. Expected values come from a behavioural model that picks the
// winner as the valid index at the smallest circular distance from the
// pointer (or the smallest index for fixed priority).
module tb_cbus_arbiter_n;
    import common::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  ireqs     [N];
    cbus_resp_t iresps_rr [N];
    cbus_resp_t iresps_fp [N];
    cbus_req_t  oreq_rr, oreq_fp;
    cbus_resp_t oresp;
    logic       busy_rr, busy_fp;
    logic [1:0] gi_rr, gi_fp;

    cbus_req_t  ireq1  [1];
    cbus_resp_t iresp1 [1];
    cbus_req_t  oreq1;
    logic       busy1;
    logic [0:0] gi1;

    cbus_arbiter_n #(.NREQ(N), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_rr),
        .oreq(oreq_rr), .oresp(oresp), .busy(busy_rr), .grant_idx(gi_rr)
    );

    cbus_arbiter_n #(.NREQ(N), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_fp),
        .oreq(oreq_fp), .oresp(oresp), .busy(busy_fp), .grant_idx(gi_fp)
    );

    cbus_arbiter_n #(.NREQ(1)) dut_one (
        .clk(clk), .reset(reset), .ireqs(ireq1), .iresps(iresp1),
        .oreq(oreq1), .oresp(oresp), .busy(busy1), .grant_idx(gi1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state per instance: 0 = rr, 1 = fixed priority, 2 = single port.
    bit m_busy [3];
    int m_own  [3];
    int m_ptr  [3];

    function automatic int pick(input bit rr, input int n, input int ptr, input logic [N-1:0] v);
        int best, best_d, d;
        best   = -1;
        best_d = n;
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin
                d = rr ? (i - ptr + n) % n : i;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    function automatic cbus_req_t exp_oreq(input int k);
        if (!m_busy[k]) return '0;
        return (k == 2) ? ireq1[0] : ireqs[m_own[k]];
    endfunction

    function automatic cbus_resp_t exp_iresp(input int k, input int i);
        return (m_busy[k] && m_own[k] == i) ? oresp : '0;
    endfunction

    function automatic cbus_req_t rand_req(input bit v);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'($urandom);
        r.size     = 3'($urandom);
        r.addr     = {$urandom, $urandom};
        r.strobe   = 8'($urandom);
        r.data     = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       r.len = MLEN1;
            1:       r.len = MLEN2;
            2:       r.len = MLEN4;
            default: r.len = MLEN8;
        endcase
        r.burst = 2'($urandom);
        return r;
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic step();
        logic [N-1:0] v, vk;
        bit nb [3];
        int no [3], np [3];
        int n;
        for (int i = 0; i < N; i++) v[i] = ireqs[i].valid;
        for (int k = 0; k < 3; k++) begin
            n     = (k == 2) ? 1 : N;
            vk    = (k == 2) ? N'(ireq1[0].valid) : v;
            nb[k] = m_busy[k];
            no[k] = m_own[k];
            np[k] = m_ptr[k];
            if (reset) begin
                nb[k] = 0; no[k] = 0; np[k] = 0;
            end else if (!m_busy[k]) begin
                if (vk != '0) begin
                    nb[k] = 1;
                    no[k] = pick(k != 1, n, m_ptr[k], vk);
                end
            end else if (oresp.ready && oresp.last) begin
                nb[k] = 0;
                if (k != 1) np[k] = (m_own[k] + 1) % n;
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb;
        m_own  = no;
        m_ptr  = np;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        ireq1[0] = '0;
        oresp    = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset    = 1'b1;
        ireqs[1] = rand_req(1'b1);
        step();
        step();
        vectors++;
        if ({busy_rr, busy_fp, busy1} !== 3'b000)
            begin miscompares++; $display("FAIL reset_busy: got %b expected 000", {busy_rr, busy_fp, busy1}); end
        vectors++;
        if ({gi_rr, gi_fp, gi1} !== 5'b0)
            begin miscompares++; $display("FAIL reset_grant_idx: got %b expected 00000", {gi_rr, gi_fp, gi1}); end
        vectors++;
        if (oreq_rr !== '0 || oreq_fp !== '0 || oreq1 !== '0)
            begin miscompares++; $display("FAIL reset_oreq: got %h expected 0", oreq_rr); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (iresps_rr[i] !== '0 || iresps_fp[i] !== '0)
                begin miscompares++; $display("FAIL reset_iresps[%0d]: got %h expected 0", i, iresps_rr[i]); end
        end
        vectors++;
        if (dut_rr.rr_ptr !== 2'd0)
            begin miscompares++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut_rr.rr_ptr); end
        clear_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        cbus_resp_t e;
        ireqs[2]       = '0;
        ireqs[2].valid = 1'b1;
        ireqs[2].addr  = 64'h0000_0000_8000_0040;
        ireqs[2].len   = MLEN4;
        #1;
        vectors++;
        if (oreq_rr !== '0)
            begin miscompares++; $display("FAIL single_no_comb_path: got %h expected 0", oreq_rr); end
        step();
        vectors++;
        if (busy_rr !== 1'b1 || gi_rr !== 2'd2 || oreq_rr.addr !== 64'h8000_0040)
            begin miscompares++; $display("FAIL single_grant: got busy=%b idx=%0d addr=%h expected 1/2/80000040", busy_rr, gi_rr, oreq_rr.addr); end
        for (int b = 0; b < 4; b++) begin
            oresp.ready = 1'b1;
            oresp.last  = (b == 3);
            oresp.data  = {$urandom, $urandom};
            #1;
            for (int i = 0; i < N; i++) begin
                e = (i == 2) ? oresp : '0;
                vectors++;
                if (iresps_rr[i] !== e)
                    begin miscompares++; $display("FAIL single_beat%0d_iresps[%0d]: got %h expected %h", b, i, iresps_rr[i], e); end
            end
            step();
        end
        clear_inputs();
        #1;
        vectors++;
        if (busy_rr !== 1'b0 || dut_rr.rr_ptr !== 2'd3)
            begin miscompares++; $display("FAIL single_done: got busy=%b rr_ptr=%0d expected 0/3", busy_rr, dut_rr.rr_ptr); end
    endtask

    task automatic test_rr_fairness();
        int order [6] = '{0, 1, 3, 0, 1, 3};
        reset = 1'b1;
        step();
        reset = 1'b0;
        foreach (order[g]) if (g < 3) begin
            ireqs[order[g]]     = rand_req(1'b1);
            ireqs[order[g]].len = MLEN1;
        end
        for (int g = 0; g < 6; g++) begin
            step();
            vectors++;
            if (busy_rr !== 1'b1 || gi_rr !== 2'(order[g]))
                begin miscompares++; $display("FAIL rr_order[%0d]: got busy=%b idx=%0d expected 1/%0d", g, busy_rr, gi_rr, order[g]); end
            vectors++;
            if (gi_fp !== 2'd0)
                begin miscompares++; $display("FAIL fp_shared_order[%0d]: got %0d expected 0", g, gi_fp); end
            oresp.ready = 1'b1;
            oresp.last  = 1'b1;
            step();
            oresp = '0;
            vectors++;
            if (busy_rr !== 1'b0)
                begin miscompares++; $display("FAIL rr_bubble[%0d]: got busy=%b expected 0", g, busy_rr); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_fixed_priority();
        ireqs[0] = rand_req(1'b1);
        ireqs[2] = rand_req(1'b1);
        for (int g = 0; g < 4; g++) begin
            step();
            vectors++;
            if (busy_fp !== 1'b1 || gi_fp !== 2'd0)
                begin miscompares++; $display("FAIL fp_grant[%0d]: got busy=%b idx=%0d expected 1/0", g, busy_fp, gi_fp); end
            vectors++;
            if (gi_rr !== 2'(m_own[0]))
                begin miscompares++; $display("FAIL fp_rr_alt[%0d]: got %0d expected %0d", g, gi_rr, m_own[0]); end
            oresp.ready = 1'b1;
            oresp.last  = 1'b1;
            step();
            oresp = '0;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_lock();
        ireqs[1]          = rand_req(1'b1);
        ireqs[1].is_write = 1'b1;
        ireqs[1].len      = MLEN8;
        step();
        vectors++;
        if (busy_rr !== 1'b1 || gi_rr !== 2'd1 || gi_fp !== 2'd1)
            begin miscompares++; $display("FAIL lock_grant: got rr=%0d fp=%0d expected 1/1", gi_rr, gi_fp); end
        for (int b = 0; b < 8; b++) begin
            if (b == 2) ireqs[0] = rand_req(1'b1);
            ireqs[1].data  = {$urandom, $urandom};
            ireqs[1].valid = (b != 5);
            oresp.ready    = 1'b1;
            oresp.last     = (b == 7);
            #1;
            vectors++;
            if (oreq_rr !== ireqs[1] || gi_rr !== 2'd1 || busy_rr !== 1'b1)
                begin miscompares++; $display("FAIL lock_beat%0d: got idx=%0d oreq=%h expected 1/%h", b, gi_rr, oreq_rr, ireqs[1]); end
            step();
        end
        oresp    = '0;
        ireqs[1] = '0;
        #1;
        vectors++;
        if (busy_rr !== 1'b0)
            begin miscompares++; $display("FAIL lock_release: got busy=%b expected 0", busy_rr); end
        step();
        vectors++;
        if (busy_rr !== 1'b1 || gi_rr !== 2'd0)
            begin miscompares++; $display("FAIL lock_next_grant: got busy=%b idx=%0d expected 1/0", busy_rr, gi_rr); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        ireqs[0]          = rand_req(1'b1);
        ireqs[3]          = rand_req(1'b1);
        ireqs[3].is_write = 1'b1;
        ireqs[3].len      = MLEN4;
        step();
        vectors++;
        if (gi_rr !== 2'd3)
            begin miscompares++; $display("FAIL rstmid_first_grant: got %0d expected 3", gi_rr); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        oresp = '0;
        #1;
        vectors++;
        if (busy_rr !== 1'b0 || oreq_rr.valid !== 1'b0 || gi_rr !== 2'd0 || dut_rr.rr_ptr !== 2'd0)
            begin miscompares++; $display("FAIL rstmid_state: got busy=%b valid=%b idx=%0d ptr=%0d expected 0/0/0/0", busy_rr, oreq_rr.valid, gi_rr, dut_rr.rr_ptr); end
        step();
        vectors++;
        if (busy_rr !== 1'b1 || gi_rr !== 2'd0)
            begin miscompares++; $display("FAIL rstmid_regrant: got busy=%b idx=%0d expected 1/0", busy_rr, gi_rr); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_ready_no_last();
        ireqs[2] = rand_req(1'b1);
        step();
        for (int b = 0; b < 6; b++) begin
            oresp.ready = (b < 3);
            oresp.last  = (b >= 3);
            oresp.data  = {$urandom, $urandom};
            step();
            vectors++;
            if (busy_rr !== 1'b1 || gi_rr !== 2'd2)
                begin miscompares++; $display("FAIL no_last_hold[%0d]: got busy=%b idx=%0d expected 1/2", b, busy_rr, gi_rr); end
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        vectors++;
        if (busy_rr !== 1'b0)
            begin miscompares++; $display("FAIL no_last_finish: got busy=%b expected 0", busy_rr); end
        clear_inputs();
        step();
    endtask

    task automatic test_single_port();
        ireq1[0] = rand_req(1'b1);
        #1;
        vectors++;
        if (oreq1 !== '0)
            begin miscompares++; $display("FAIL one_no_comb_path: got %h expected 0", oreq1); end
        step();
        vectors++;
        if (busy1 !== 1'b1 || gi1 !== 1'b0 || oreq1 !== ireq1[0])
            begin miscompares++; $display("FAIL one_grant: got busy=%b idx=%0d oreq=%h", busy1, gi1, oreq1); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        oresp = '0;
        vectors++;
        if (busy1 !== 1'b0)
            begin miscompares++; $display("FAIL one_bubble: got busy=%b expected 0", busy1); end
        step();
        vectors++;
        if (busy1 !== 1'b1 || gi1 !== 1'b0)
            begin miscompares++; $display("FAIL one_regrant: got busy=%b idx=%0d expected 1/0", busy1, gi1); end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        logic       a_busy [3];
        int         a_gi   [3];
        cbus_req_t  a_oreq [3];
        cbus_resp_t e;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) ireqs[i] = rand_req($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 3) == 0) ireq1[0] = rand_req($urandom_range(0, 9) < 4);
            oresp.ready = ($urandom_range(0, 9) < 6);
            oresp.last  = ($urandom_range(0, 9) < 3);
            oresp.data  = {$urandom, $urandom};
            reset       = ($urandom_range(0, 63) == 0);
            #1;
            a_busy = '{busy_rr, busy_fp, busy1};
            a_gi   = '{int'(gi_rr), int'(gi_fp), int'(gi1)};
            a_oreq = '{oreq_rr, oreq_fp, oreq1};
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (a_busy[k] !== m_busy[k])
                    begin miscompares++; $display("FAIL rand_busy[%0d] cyc %0d: got %b expected %b", k, c, a_busy[k], m_busy[k]); end
                if (m_busy[k]) begin
                    vectors++;
                    if (a_gi[k] != m_own[k])
                        begin miscompares++; $display("FAIL rand_grant[%0d] cyc %0d: got %0d expected %0d", k, c, a_gi[k], m_own[k]); end
                end
                vectors++;
                if (a_oreq[k] !== exp_oreq(k))
                    begin miscompares++; $display("FAIL rand_oreq[%0d] cyc %0d: got %h expected %h", k, c, a_oreq[k], exp_oreq(k)); end
            end
            for (int i = 0; i < N; i++) begin
                e = exp_iresp(0, i);
                vectors++;
                if (iresps_rr[i] !== e)
                    begin miscompares++; $display("FAIL rand_iresp_rr[%0d] cyc %0d: got %h expected %h", i, c, iresps_rr[i], e); end
                e = exp_iresp(1, i);
                vectors++;
                if (iresps_fp[i] !== e)
                    begin miscompares++; $display("FAIL rand_iresp_fp[%0d] cyc %0d: got %h expected %h", i, c, iresps_fp[i], e); end
            end
            vectors++;
            if (iresp1[0] !== exp_iresp(2, 0))
                begin miscompares++; $display("FAIL rand_iresp_one cyc %0d: got %h expected %h", c, iresp1[0], exp_iresp(2, 0)); end
            step();
        end
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed_priority();
        test_lock();
        test_reset_mid_burst();
        test_ready_no_last();
        test_single_port();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
